// File: rtl/input_cmd_queue.sv
// Per-frame button sampler turning presses and held-direction auto-repeat into 3-bit commands.
// Commands sit in a DEPTH-entry FIFO with a registered head; it drops new commands when full.
module input_cmd_queue #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              buttons,
  input  logic                     vga_vs,
  input  logic                     cmd_ready,
  output logic                     cmd_valid,
  output logic [2:0]               cmd_code,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     frame_tick
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(REPEAT_DELAY + 1);

  logic          vs_s1, vs_s2, vs_s3;
  logic [6:0]    cur, prev, nw;
  logic [2:0]    dir, dir_q, press, sel;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          rep, push, do_pop, do_push, full;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [2:0]    head_n;
  logic          unused_btn;

  // C, X, Y, Z never produce commands; only the used buttons are tracked.
  assign cur        = {buttons[10], buttons[5:0]};
  assign unused_btn = ^buttons[9:6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_s3      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= vga_vs;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      frame_tick <= vs_s3 & ~vs_s2;
    end
  end

  always_comb begin
    nw     = cur & ~prev;
    press  = 3'd0;
    if      (nw[6]) press = 3'd7;
    else if (nw[4]) press = 3'd5;
    else if (nw[5]) press = 3'd6;
    else if (nw[0]) press = 3'd1;
    else if (nw[1]) press = 3'd2;
    else if (nw[2]) press = 3'd3;
    else if (nw[3]) press = 3'd4;
    dir = 3'd0;
    if      (cur[0]) dir = 3'd1;
    else if (cur[1]) dir = 3'd2;
    else if (cur[2]) dir = 3'd3;
    else if (cur[3]) dir = 3'd4;
    // The frame a direction first appears counts as held frame 1.
    hold_n = hold_cnt;
    rep    = 1'b0;
    if (dir == 3'd0)
      hold_n = '0;
    else if (dir != dir_q)
      hold_n = HW'(1);
    else if (hold_cnt + HW'(1) == HW'(REPEAT_DELAY)) begin
      hold_n = HW'(REPEAT_DELAY - REPEAT_RATE);
      rep    = 1'b1;
    end else
      hold_n = hold_cnt + HW'(1);
    sel = (press != 3'd0) ? press : (rep ? dir : 3'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '1;
      dir_q    <= 3'd0;
      hold_cnt <= '0;
    end else if (frame_tick) begin
      prev     <= cur;
      dir_q    <= dir;
      hold_cnt <= hold_n;
    end
  end

  assign push      = frame_tick && (sel != 3'd0);
  assign cmd_valid = (fifo_count != '0);
  assign full      = (fifo_count == CW'(DEPTH));
  assign do_pop    = cmd_valid & cmd_ready;
  assign do_push   = push & (~full | do_pop);
  assign rd_nxt    = rd_ptr + PW'(1);

  // Head is kept in its own register so it updates on the same edge as the write.
  always_comb begin
    head_n = cmd_code;
    if (do_pop) begin
      if (fifo_count > CW'(1)) head_n = mem[rd_nxt];
      else if (do_push)        head_n = sel;
    end else if (!cmd_valid && do_push) begin
      head_n = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      cmd_code   <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      cmd_code <= head_n;
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_push && !do_pop)      fifo_count <= fifo_count + CW'(1);
      else if (do_pop && !do_push) fifo_count <= fifo_count - CW'(1);
      if (push && !do_push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_input_cmd_queue.sv
// Directed bench for input_cmd_queue: presses, priority, auto-repeat, FIFO full/overflow, async reset.
module tb_input_cmd_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] buttons;
  logic        vga_vs;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] seq   [9] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020, 11'h400, 11'h001, 11'h002};
  logic [2:0]  codes [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};

  input_cmd_queue dut (
    .clk(clk), .reset(reset), .buttons(buttons), .vga_vs(vga_vs),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .fifo_count(fifo_count), .overflow(overflow), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One vsync pulse; cmd_ready can be raised only for the push cycle.
  task automatic frame(input logic rdy);
    @(posedge clk); #1 vga_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("frame_tick", 32'(frame_tick), 32'd1);
    cmd_ready = rdy;
    @(posedge clk); #1 cmd_ready = 1'b0;
    vga_vs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pop(input logic [2:0] exp, input string tag);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    check({tag, "_code"}, 32'(cmd_code), 32'(exp));
    cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; buttons = 11'h001; vga_vs = 1'b1; cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_code", 32'(cmd_code), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    // 1: UP held through reset must not fire; a fresh press does, 4 clk after vs falls
    repeat (3) frame(1'b0);
    check("t1_hold_count", 32'(fifo_count), 32'd0);
    buttons = 11'h000; frame(1'b0);
    buttons = 11'h001;
    @(posedge clk); #1 vga_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("t1_tick3", 32'(frame_tick), 32'd1);
    check("t1_valid3", 32'(cmd_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid4", 32'(cmd_valid), 32'd1);
    check("t1_code4", 32'(cmd_code), 32'd1);
    vga_vs = 1'b1;
    repeat (4) @(posedge clk); #1;
    pop(3'd1, "t1_pop");
    check("t1_empty", 32'(fifo_count), 32'd0);
    buttons = 11'h000; frame(1'b0);

    // 2: A and LEFT in the same frame -> only A
    buttons = 11'h014; frame(1'b0);
    check("t2_count", 32'(fifo_count), 32'd1);
    pop(3'd5, "t2_pop");
    check("t2_empty", 32'(fifo_count), 32'd0);
    buttons = 11'h000; frame(1'b0);

    // 3: hold RIGHT 32 frames -> entries at frames 1, 20, 26, 32
    buttons = 11'h008;
    for (int f = 1; f <= 32; f++) begin
      frame(1'b0);
      if (f == 1)  check("t3_f1", 32'(fifo_count), 32'd1);
      if (f == 19) check("t3_f19", 32'(fifo_count), 32'd1);
      if (f == 20) check("t3_f20", 32'(fifo_count), 32'd2);
      if (f == 25) check("t3_f25", 32'(fifo_count), 32'd2);
      if (f == 26) check("t3_f26", 32'(fifo_count), 32'd3);
    end
    check("t3_f32", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) pop(3'd4, "t3_pop");
    buttons = 11'h000; frame(1'b0);
    check("t3_release", 32'(fifo_count), 32'd0);
    buttons = 11'h002;
    for (int f = 1; f <= 20; f++) begin
      frame(1'b0);
      if (f == 1)  check("t3_down_f1", 32'(fifo_count), 32'd1);
      if (f == 19) check("t3_down_f19", 32'(fifo_count), 32'd1);
    end
    check("t3_down_f20", 32'(fifo_count), 32'd2);
    pop(3'd2, "t3_down_pop");
    pop(3'd2, "t3_down_pop");
    buttons = 11'h000; frame(1'b0);

    // 4: 9 presses with no pops -> 8 kept, overflow set
    for (int i = 0; i < 8; i++) begin buttons = seq[i]; frame(1'b0); end
    check("t4_count8", 32'(fifo_count), 32'd8);
    check("t4_ovf0", 32'(overflow), 32'd0);
    buttons = seq[8]; frame(1'b0);
    check("t4_count_full", 32'(fifo_count), 32'd8);
    check("t4_ovf1", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) pop(codes[i], "t4_pop");
    check("t4_empty", 32'(fifo_count), 32'd0);

    // 5: full FIFO with pop on the push cycle -> both succeed
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    buttons = 11'h000; frame(1'b0);
    for (int i = 0; i < 8; i++) begin buttons = seq[i]; frame(1'b0); end
    check("t5_full", 32'(fifo_count), 32'd8);
    buttons = seq[8]; frame(1'b1);
    check("t5_count", 32'(fifo_count), 32'd8);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_head", 32'(cmd_code), 32'd2);
    for (int i = 1; i < 9; i++) pop(codes[i], "t5_pop");
    check("t5_empty", 32'(fifo_count), 32'd0);

    // 6: async reset with 5 queued, A held through reset does not fire
    buttons = 11'h000; frame(1'b0);
    for (int i = 0; i < 5; i++) begin buttons = seq[i]; frame(1'b0); end
    check("t6_count5", 32'(fifo_count), 32'd5);
    @(posedge clk); #3 reset = 1'b1;
    #1 check("t6_async_valid", 32'(cmd_valid), 32'd0);
    check("t6_async_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    frame(1'b0);
    check("t6_no_spurious", 32'(fifo_count), 32'd0);
    buttons = 11'h000; frame(1'b0);
    check("t6_release", 32'(fifo_count), 32'd0);
    buttons = 11'h010; frame(1'b0);
    check("t6_repress_count", 32'(fifo_count), 32'd1);
    check("t6_repress_code", 32'(cmd_code), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
